// File: rtl/digit_entry_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : digit_entry_accumulator
// Description : Builds a signed two's-complement operand from keypad edits
//               (digit entry, backspace, sign toggle, clear). Up to six BCD
//               digits are held. After every accepted edit the binary value
//               is re-derived by a six-step multiply-by-10 FSM.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous, active-high reset
//               key_valid  - digit key pressed this cycle
//               key_digit  - digit code (legal 0..9)
//               key_neg    - toggle sign
//               key_back   - delete least-significant digit
//               key_clear  - clear entry (acts in any state)
//               ready      - edits accepted (low while converting)
//               value      - signed result, two's complement
//               length     - digits held, 0..MAX_DIGITS
//               neg        - current sign flag
//               done       - one-cycle pulse when value has been updated
//               err        - one-cycle pulse when an edit is rejected
// Revision    : 1.0 - initial release
// ============================================================================
module digit_entry_accumulator #(
    parameter int WIDTH      = 22,
    parameter int MAX_DIGITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_digit,
    input  logic             key_neg,
    input  logic             key_back,
    input  logic             key_clear,
    output logic             ready,
    output logic [WIDTH-1:0] value,
    output logic [2:0]       length,
    output logic             neg,
    output logic             done,
    output logic             err
);

    localparam int          c_bcd_w   = 24;
    localparam int          c_acc_w   = WIDTH - 1;
    localparam logic [2:0]  c_max_len = 3'(MAX_DIGITS);
    localparam logic [2:0]  c_last    = 3'd5;

    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_CONV = 1'b1;

    logic [0:0]         r_state;
    logic [c_bcd_w-1:0] r_bcd;
    logic [c_acc_w-1:0] r_acc;
    logic [2:0]         r_cnt;
    logic [2:0]         r_length;
    logic               r_neg;
    logic [WIDTH-1:0]   r_value;
    logic               r_ready;
    logic               r_done;
    logic               r_err;

    logic [2:0]         w_sel;
    logic [3:0]         w_digit;
    logic [c_acc_w-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mag;

    // Digits are consumed MSD first; unused upper digits are zero, so a
    // fixed six iterations always yields the right magnitude.
    assign w_sel      = c_last - r_cnt;
    assign w_digit    = r_bcd[{w_sel, 2'b00} +: 4];
    assign w_acc_next = (r_acc << 3) + (r_acc << 1)
                      + {{(c_acc_w-4){1'b0}}, w_digit};
    assign w_mag      = {1'b0, w_acc_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bcd    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_length <= '0;
            r_neg    <= 1'b0;
            r_value  <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (key_clear) begin
                // Clear wins over everything and aborts a running conversion.
                r_state  <= S_IDLE;
                r_bcd    <= '0;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_length <= '0;
                r_neg    <= 1'b0;
                r_value  <= '0;
                r_ready  <= 1'b1;
                r_done   <= 1'b1;
            end else if (r_state == S_IDLE) begin
                if (key_back) begin
                    if (r_length != 3'd0) begin
                        r_bcd    <= r_bcd >> 4;
                        r_length <= r_length - 3'd1;
                        r_state  <= S_CONV;
                        r_ready  <= 1'b0;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end else if (key_neg) begin
                    r_neg   <= ~r_neg;
                    r_state <= S_CONV;
                    r_ready <= 1'b0;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else if (key_valid) begin
                    if ((key_digit > 4'd9) || (r_length == c_max_len)) begin
                        r_err <= 1'b1;
                    end else if (!((key_digit == 4'd0) && (r_length == 3'd0))) begin
                        // A leading zero falls through silently.
                        r_bcd    <= {r_bcd[c_bcd_w-5:0], key_digit};
                        r_length <= r_length + 3'd1;
                        r_state  <= S_CONV;
                        r_ready  <= 1'b0;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == c_last) begin
                    // value only changes here, so it never shows a partial sum.
                    r_value <= r_neg ? (-w_mag) : w_mag;
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign ready  = r_ready;
    assign value  = r_value;
    assign length = r_length;
    assign neg    = r_neg;
    assign done   = r_done;
    assign err    = r_err;

endmodule
`default_nettype wire
